// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 front end: idle line level and default filter length.
package ps2_pkg;
  localparam logic PS2_IDLE_LEVEL            = 1'b1;
  localparam int   PS2_STABLE_CYCLES_DEFAULT = 20;
endpackage

// File: rtl/ps2_debouncer_if.sv
// Raw PS/2 pins in, conditioned levels out; master drives the pins, slave is the debouncer.
interface ps2_debouncer_if;
  logic I0;
  logic I1;
  logic O0;
  logic O1;

  modport master (output I0, output I1, input  O0, input  O1);
  modport slave  (input  I0, input  I1, output O0, output O1);
endinterface

// File: rtl/ps2_debouncer_channel.sv
// Single-bit debounce filter: optional 2-flop synchronizer (DEBOUNCER_SYNC_EN) then stability counter.
// Latency: STABLE_CYCLES edges after the sampled level changes (+2 with the synchronizer).
// Backpressure: none, free-running level filter.
module debounce_channel
  import ps2_pkg::*;
#(
  parameter int STABLE_CYCLES = PS2_STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {2{PS2_IDLE_LEVEL}};
    else     sync_q <= {sync_q[0], din};
  end

  assign s = sync_q[1];
`else
  assign s = din;
`endif

  // Any cycle where the sample agrees with the output restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= PS2_IDLE_LEVEL;
      cnt  <= '0;
    end else if (s == dout) begin
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      dout <= s;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_debouncer.sv
// Two-channel PS/2 clock/data debouncer; DEBOUNCER_SYNC_EN adds a 2-flop synchronizer per channel.
// Latency: STABLE_CYCLES edges (STABLE_CYCLES+2 with DEBOUNCER_SYNC_EN); outputs registered.
// Backpressure: none, both channels filtered independently every clock.
module ps2_debouncer
  import ps2_pkg::*;
#(
  parameter int STABLE_CYCLES = PS2_STABLE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  ps2_debouncer_if.slave  ps2
);

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch0 (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2.I0),
    .dout (ps2.O0)
  );

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch1 (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2.I1),
    .dout (ps2.O1)
  );

endmodule

// File: tb/tb_ps2_debouncer.sv
// Directed bench for ps2_debouncer with STABLE_CYCLES=4; expected latency follows DEBOUNCER_SYNC_EN.
module tb_ps2_debouncer;

  localparam int N = 4;
`ifdef DEBOUNCER_SYNC_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N;
`endif
  localparam int NEVER = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ps2_debouncer_if bus ();

  ps2_debouncer #(.STABLE_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .ps2 (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  // Restore idle-high pins and let both channels return to 1.
  task automatic settle();
    bus.I0 = 1'b1;
    bus.I1 = 1'b1;
    for (int e = 1; e <= LAT + 2; e++) step();
    chk("settle_o0", 0, bus.O0, 1'b1);
    chk("settle_o1", 0, bus.O1, 1'b1);
  endtask

  initial begin
    // Reset with pins held low: outputs must sit at idle-high.
    bus.I0 = 1'b0;
    bus.I1 = 1'b0;
    rst    = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("reset_o0", e, bus.O0, 1'b1);
      chk("reset_o1", e, bus.O1, 1'b1);
    end
    rst = 1'b0;
    step();
    chk("post_reset_o0", 0, bus.O0, 1'b1);
    chk("post_reset_o1", 0, bus.O1, 1'b1);
    settle();

    // Clean falling edge on channel 0.
    bus.I0 = 1'b0;
    for (int e = 1; e <= LAT + 2; e++) begin
      step();
      chk("clean_o0", e, bus.O0, (e >= LAT) ? 1'b0 : 1'b1);
      chk("clean_o1", e, bus.O1, 1'b1);
    end
    settle();

    // 3-clock low pulse on channel 1 is rejected.
    for (int e = 1; e <= 3 + LAT + 2; e++) begin
      bus.I1 = (e <= 3) ? 1'b0 : 1'b1;
      step();
      chk("glitch3_o1", e, bus.O1, 1'b1);
    end
    settle();

    // 4-clock low pulse on channel 1 passes: falls at LAT, rises LAT edges after the return.
    for (int e = 1; e <= 4 + LAT + 2; e++) begin
      bus.I1 = (e <= 4) ? 1'b0 : 1'b1;
      step();
      chk("pulse4_o1", e, bus.O1, (e >= LAT && e < 4 + LAT) ? 1'b0 : 1'b1);
      chk("pulse4_o0", e, bus.O0, 1'b1);
    end
    settle();

    // Bounce: toggle every clock for 10 clocks, then settle low.
    for (int e = 1; e <= 10 + LAT + 2; e++) begin
      bus.I0 = (e <= 10) ? ((e % 2 == 1) ? 1'b0 : 1'b1) : 1'b0;
      step();
      chk("bounce_o0", e, bus.O0, (e >= 10 + LAT) ? 1'b0 : 1'b1);
    end
    settle();

    // Simultaneous fall on both channels.
    bus.I0 = 1'b0;
    bus.I1 = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      step();
      chk("simul_o0", e, bus.O0, (e >= LAT) ? 1'b0 : 1'b1);
      chk("simul_o1", e, bus.O1, (e >= LAT) ? 1'b0 : 1'b1);
    end
    settle();

    // Reset pulse mid-count discards progress; fall comes LAT edges after release.
    bus.I0 = 1'b0;
    for (int e = 1; e <= 3 + LAT + 1; e++) begin
      rst = (e == 3) ? 1'b1 : 1'b0;
      step();
      chk("midrst_o0", e, bus.O0, (e >= 3 + LAT) ? 1'b0 : 1'b1);
      chk("midrst_o1", e, bus.O1, 1'b1);
    end
    rst = 1'b0;
    settle();

    // Held-low channel after a completed fall must stay low, not re-toggle.
    bus.I1 = 1'b0;
    for (int e = 1; e <= LAT + 3 * N; e++) begin
      step();
      chk("hold_o1", e, bus.O1, (e >= LAT && e < NEVER) ? 1'b0 : 1'b1);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
